// File: rtl/tt_sweep_pkg.sv
// Shared types and helpers for the truth-table sweep driver.
// Row numbering follows the MSB-first hex naming of gate functions.
package tt_sweep_pkg;

    typedef enum logic [1:0] {
        IDLE,
        DRIVE,
        DONE
    } sweep_state_t;

    localparam int N_ROWS = 8;

    typedef logic [7:0] tt_word_t;

    function automatic logic [2:0] row_to_bit(input logic [2:0] row);
        return 3'd7 - row;
    endfunction

endpackage

// File: rtl/tt_sweep_driver_settle_timer.sv
// Loadable 8-bit down-counter that times each row's settle hold.
// zero flags the last cycle of the hold.
module tt_settle_timer (
    input  logic       clk,
    input  logic       rst,
    input  logic       load,
    input  logic       dec,
    input  logic [7:0] value,
    output logic       zero
);

    logic [7:0] cnt_q;
    logic [7:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load) begin
            cnt_d = value;
        end else if (dec && (cnt_q != 8'd0)) begin
            cnt_d = cnt_q - 8'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= 8'd0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign zero = (cnt_q == 8'd0);

endmodule

// File: rtl/tt_sweep_driver.sv
// Drives a 3-input gate through all 8 rows and captures its truth table.
// The word is committed only when the last row is sampled.
module tt_sweep_driver
    import tt_sweep_pkg::*;
#(
    parameter int       SETTLE_CYCLES = 4,
    parameter tt_word_t EXPECTED      = 8'h44
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic       abort,
    input  logic       gate_out,
    output logic       in1,
    output logic       in2,
    output logic       in3,
    output logic       busy,
    output logic       done,
    output logic [7:0] tt_word,
    output logic       match
);

    localparam logic [7:0] RELOAD = 8'(SETTLE_CYCLES - 1);
    localparam logic [2:0] LAST_ROW = 3'(N_ROWS - 1);

    sweep_state_t state_q, state_d;
    logic [2:0]   row_q, row_d;
    logic [2:0]   in_q, in_d;
    tt_word_t     shadow_q, shadow_d;
    tt_word_t     tt_word_q, tt_word_d;
    logic         busy_q, busy_d;
    logic         done_q, done_d;
    logic         match_q, match_d;
    logic         tmr_load;
    logic         tmr_dec;
    logic         tmr_zero;

    tt_settle_timer u_timer (
        .clk   (clk),
        .rst   (rst),
        .load  (tmr_load),
        .dec   (tmr_dec),
        .value (RELOAD),
        .zero  (tmr_zero)
    );

    always_comb begin
        state_d   = state_q;
        row_d     = row_q;
        in_d      = in_q;
        shadow_d  = shadow_q;
        tt_word_d = tt_word_q;
        busy_d    = busy_q;
        done_d    = 1'b0;
        match_d   = match_q;
        tmr_load  = 1'b0;
        tmr_dec   = 1'b0;
        unique case (state_q)
            IDLE: begin
                in_d   = 3'b000;
                busy_d = 1'b0;
                if (start) begin
                    state_d  = DRIVE;
                    row_d    = 3'd0;
                    shadow_d = 8'h00;
                    busy_d   = 1'b1;
                    tmr_load = 1'b1;
                end
            end
            DRIVE: begin
                if (abort) begin
                    state_d = IDLE;
                    row_d   = 3'd0;
                    busy_d  = 1'b0;
                    in_d    = 3'b000;
                end else if (!tmr_zero) begin
                    tmr_dec = 1'b1;
                end else begin
                    shadow_d[row_to_bit(row_q)] = gate_out;
                    if (row_q != LAST_ROW) begin
                        row_d    = row_q + 3'd1;
                        in_d     = row_q + 3'd1;
                        tmr_load = 1'b1;
                    end else begin
                        // shadow_d already holds the final sample here
                        state_d   = DONE;
                        row_d     = 3'd0;
                        tt_word_d = shadow_d;
                        match_d   = (shadow_d == EXPECTED);
                        done_d    = 1'b1;
                        busy_d    = 1'b0;
                        in_d      = 3'b000;
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            row_q     <= 3'd0;
            in_q      <= 3'b000;
            shadow_q  <= 8'h00;
            tt_word_q <= 8'h00;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            match_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            row_q     <= row_d;
            in_q      <= in_d;
            shadow_q  <= shadow_d;
            tt_word_q <= tt_word_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            match_q   <= match_d;
        end
    end

    assign in1     = in_q[2];
    assign in2     = in_q[1];
    assign in3     = in_q[0];
    assign busy    = busy_q;
    assign done    = done_q;
    assign tt_word = tt_word_q;
    assign match   = match_q;

endmodule

// File: tb/tb_tt_sweep_driver.sv
// Directed bench for tt_sweep_driver with a modelled 0x44 gate.
// Instance a uses SETTLE_CYCLES=4, instance b uses SETTLE_CYCLES=1.
module tb_tt_sweep_driver;

    logic clk = 1'b0;
    logic rst;
    logic start_a, abort_a, stuck_a;
    logic start_b, abort_b;
    logic gate_a, gate_b;
    logic in1_a, in2_a, in3_a, busy_a, done_a, match_a;
    logic in1_b, in2_b, in3_b, busy_b, done_b, match_b;
    logic [7:0] tt_a, tt_b;
    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    // 0x44 gate: high only for rows 001 and 101
    assign gate_a = stuck_a | (~in2_a & in3_a);
    assign gate_b = ~in2_b & in3_b;

    tt_sweep_driver #(.SETTLE_CYCLES(4), .EXPECTED(8'h44)) dut_a (
        .clk(clk), .rst(rst), .start(start_a), .abort(abort_a),
        .gate_out(gate_a), .in1(in1_a), .in2(in2_a), .in3(in3_a),
        .busy(busy_a), .done(done_a), .tt_word(tt_a), .match(match_a)
    );

    tt_sweep_driver #(.SETTLE_CYCLES(1), .EXPECTED(8'h44)) dut_b (
        .clk(clk), .rst(rst), .start(start_b), .abort(abort_b),
        .gate_out(gate_b), .in1(in1_b), .in2(in2_b), .in3(in3_b),
        .busy(busy_b), .done(done_b), .tt_word(tt_b), .match(match_b)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
        n_cmp++;
        if ({in1_a, in2_a, in3_a, busy_a, done_a, match_a} !== 6'b0) begin
            n_bad++;
            $display("FAIL reset_ctrl_a got %b want 000000",
                     {in1_a, in2_a, in3_a, busy_a, done_a, match_a});
        end
        n_cmp++;
        if (tt_a !== 8'h00) begin
            n_bad++;
            $display("FAIL reset_tt_a got %h want 00", tt_a);
        end
        n_cmp++;
        if ({in1_b, in2_b, in3_b, busy_b, done_b, match_b, tt_b} !== 14'b0) begin
            n_bad++;
            $display("FAIL reset_b got %b want 0",
                     {in1_b, in2_b, in3_b, busy_b, done_b, match_b, tt_b});
        end
    endtask

    task automatic test_nominal();
        logic [2:0] er;
        start_a = 1'b1;
        step();
        start_a = 1'b0;
        n_cmp++;
        if (busy_a !== 1'b1 || {in1_a, in2_a, in3_a} !== 3'b000) begin
            n_bad++;
            $display("FAIL nom_e0 got busy=%b in=%b want busy=1 in=000",
                     busy_a, {in1_a, in2_a, in3_a});
        end
        for (int e = 1; e <= 32; e++) begin
            step();
            er = (e < 32) ? 3'(e / 4) : 3'd0;
            n_cmp++;
            if ({in1_a, in2_a, in3_a} !== er || busy_a !== (e < 32)
                || done_a !== (e == 32)) begin
                n_bad++;
                $display("FAIL nom_edge%0d got in=%b busy=%b done=%b want in=%b busy=%b done=%b",
                         e, {in1_a, in2_a, in3_a}, busy_a, done_a,
                         er, (e < 32), (e == 32));
            end
        end
        n_cmp++;
        if (tt_a !== 8'h44 || match_a !== 1'b1) begin
            n_bad++;
            $display("FAIL nom_word got tt=%h match=%b want tt=44 match=1",
                     tt_a, match_a);
        end
        step();
        n_cmp++;
        if (done_a !== 1'b0 || busy_a !== 1'b0) begin
            n_bad++;
            $display("FAIL nom_after got done=%b busy=%b want 0 0", done_a, busy_a);
        end
    endtask

    task automatic test_wrong_gate();
        int pulses = 0;
        stuck_a = 1'b1;
        start_a = 1'b1;
        step();
        start_a = 1'b0;
        for (int e = 1; e <= 40; e++) begin
            step();
            if (done_a === 1'b1) pulses++;
        end
        stuck_a = 1'b0;
        n_cmp++;
        if (tt_a !== 8'hFF || match_a !== 1'b0) begin
            n_bad++;
            $display("FAIL wrong_word got tt=%h match=%b want tt=ff match=0",
                     tt_a, match_a);
        end
        n_cmp++;
        if (pulses != 1) begin
            n_bad++;
            $display("FAIL wrong_pulses got %0d want 1", pulses);
        end
    endtask

    task automatic test_abort();
        int pulses = 0;
        start_a = 1'b1;
        step();
        start_a = 1'b0;
        for (int e = 1; e <= 34; e++) step();
        n_cmp++;
        if (tt_a !== 8'h44 || match_a !== 1'b1) begin
            n_bad++;
            $display("FAIL abort_first got tt=%h match=%b want 44 1", tt_a, match_a);
        end
        start_a = 1'b1;
        step();
        start_a = 1'b0;
        for (int e = 1; e <= 9; e++) step();
        abort_a = 1'b1;
        step();
        abort_a = 1'b0;
        n_cmp++;
        if (busy_a !== 1'b0 || {in1_a, in2_a, in3_a} !== 3'b000 || done_a !== 1'b0) begin
            n_bad++;
            $display("FAIL abort_e10 got busy=%b in=%b done=%b want 0 000 0",
                     busy_a, {in1_a, in2_a, in3_a}, done_a);
        end
        for (int e = 0; e < 40; e++) begin
            step();
            if (done_a === 1'b1) pulses++;
        end
        n_cmp++;
        if (pulses != 0 || tt_a !== 8'h44 || match_a !== 1'b1) begin
            n_bad++;
            $display("FAIL abort_hold got pulses=%0d tt=%h match=%b want 0 44 1",
                     pulses, tt_a, match_a);
        end
    endtask

    task automatic test_start_held();
        int first = -1;
        int second = -1;
        int pulses = 0;
        logic busy33 = 1'b1;
        logic busy34 = 1'b0;
        start_a = 1'b1;
        step();
        for (int e = 1; e <= 66; e++) begin
            step();
            if (e == 33) busy33 = busy_a;
            if (e == 34) busy34 = busy_a;
            if (done_a === 1'b1) begin
                pulses++;
                if (first < 0) first = e;
                else second = e;
            end
        end
        start_a = 1'b0;
        step();
        step();
        n_cmp++;
        if (pulses != 2 || first != 32 || second != 66) begin
            n_bad++;
            $display("FAIL held_done got n=%0d at %0d,%0d want 2 at 32,66",
                     pulses, first, second);
        end
        n_cmp++;
        if (busy33 !== 1'b0 || busy34 !== 1'b1) begin
            n_bad++;
            $display("FAIL held_busy got %b%b want 01", busy33, busy34);
        end
        n_cmp++;
        if (busy_a !== 1'b0 || tt_a !== 8'h44) begin
            n_bad++;
            $display("FAIL held_end got busy=%b tt=%h want 0 44", busy_a, tt_a);
        end
    endtask

    task automatic test_reset_mid();
        int at = -1;
        start_a = 1'b1;
        step();
        start_a = 1'b0;
        for (int e = 1; e <= 19; e++) step();
        rst = 1'b1;
        start_a = 1'b1;
        step();
        rst = 1'b0;
        start_a = 1'b0;
        n_cmp++;
        if ({in1_a, in2_a, in3_a, busy_a, done_a, match_a} !== 6'b0
            || tt_a !== 8'h00) begin
            n_bad++;
            $display("FAIL rstmid got ctrl=%b tt=%h want 000000 00",
                     {in1_a, in2_a, in3_a, busy_a, done_a, match_a}, tt_a);
        end
        start_a = 1'b1;
        step();
        start_a = 1'b0;
        for (int e = 1; e <= 40; e++) begin
            step();
            if (done_a === 1'b1 && at < 0) at = e;
        end
        n_cmp++;
        if (at != 32 || tt_a !== 8'h44 || match_a !== 1'b1) begin
            n_bad++;
            $display("FAIL rstmid_resweep got done@%0d tt=%h match=%b want 32 44 1",
                     at, tt_a, match_a);
        end
    endtask

    task automatic test_settle1();
        start_b = 1'b1;
        step();
        start_b = 1'b0;
        for (int e = 1; e <= 8; e++) begin
            n_cmp++;
            if ({in1_b, in2_b, in3_b} !== 3'(e - 1) || busy_b !== 1'b1) begin
                n_bad++;
                $display("FAIL s1_row%0d got in=%b busy=%b want in=%b busy=1",
                         e - 1, {in1_b, in2_b, in3_b}, busy_b, 3'(e - 1));
            end
            step();
        end
        n_cmp++;
        if (done_b !== 1'b1 || busy_b !== 1'b0 || tt_b !== 8'h44
            || match_b !== 1'b1) begin
            n_bad++;
            $display("FAIL s1_done got done=%b busy=%b tt=%h match=%b want 1 0 44 1",
                     done_b, busy_b, tt_b, match_b);
        end
        step();
        n_cmp++;
        if (done_b !== 1'b0) begin
            n_bad++;
            $display("FAIL s1_pulse got done=%b want 0", done_b);
        end
    endtask

    initial begin
        rst = 1'b0;
        start_a = 1'b0;
        abort_a = 1'b0;
        stuck_a = 1'b0;
        start_b = 1'b0;
        abort_b = 1'b0;
        test_reset();
        test_nominal();
        test_wrong_gate();
        test_abort();
        test_start_held();
        test_reset_mid();
        test_settle1();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
